// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide unit.
// Holds the funct3 op encodings, the FSM states and the operand-signedness predicates.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIN  = 2'd2
  } state_e;

  function automatic logic is_div(input op_e op);
    return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction

  function automatic logic is_rem(input op_e op);
    return op inside {OP_REM, OP_REMU};
  endfunction

  function automatic logic is_signed_a(input op_e op);
    return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  function automatic logic is_signed_b(input op_e op);
    return op inside {OP_MULH, OP_DIV, OP_REM};
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the unsigned magnitude datapath: shift-add for multiply,
// restoring shift-subtract for divide, on a {hi, lo} 2*XLEN accumulator.
module muldiv_step #(
  parameter int unsigned XLEN = 32
) (
  input  logic              div_op,
  input  logic [2*XLEN-1:0] acc,
  input  logic [XLEN-1:0]   opnd,
  output logic [2*XLEN-1:0] acc_nxt
);

  logic [XLEN:0] sum;
  logic [XLEN:0] rem_sh;
  logic [XLEN:0] diff;

  // Multiply: lo holds the remaining multiplier bits, hi the partial product.
  // Divide: hi is the running remainder, lo shifts in quotient bits.
  always_comb begin : step
    sum     = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
    rem_sh  = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    diff    = rem_sh - {1'b0, opnd};
    acc_nxt = {sum, acc[XLEN-1:1]};
    if (div_op) begin
      if (!diff[XLEN]) acc_nxt = {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
      else             acc_nxt = {rem_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the EX stage; stalls the pipe while computing.
// Define MULDIV_FAST_MUL_EN for single-cycle multiplies via a 2*XLEN-bit multiplier.
module ex_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic            discard,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            busy_o,
  output logic            stall_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam int unsigned AW    = 2 * XLEN;
  localparam int unsigned CNT_W = $clog2(XLEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  op_e               op_q, op_d;
  logic              neg_q, neg_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic [AW-1:0]     acc_q, acc_d, acc_step, prod_s;
  logic              busy_q, busy_d, done_q, done_d;
  logic [XLEN-1:0]   result_q, result_d;

  op_e             op_in;
  logic            sgn_a, sgn_b, neg_in, is_dbz, is_ovf, accept, div_q, fast_hit;
  logic [XLEN-1:0] a_mag, b_mag, special_res, fast_res, quo_s, rem_s, fin_res;

  // Operand magnitudes, result sign and the single-cycle special cases.
  always_comb begin : decode
    op_in  = op_e'(op_i);
    sgn_a  = is_signed_a(op_in) & a_i[XLEN-1];
    sgn_b  = is_signed_b(op_in) & b_i[XLEN-1];
    a_mag  = sgn_a ? -a_i : a_i;
    b_mag  = sgn_b ? -b_i : b_i;
    neg_in = is_rem(op_in) ? sgn_a : (sgn_a ^ sgn_b);
    is_dbz = is_div(op_in) && (b_i == '0);
    is_ovf = is_div(op_in) && is_signed_a(op_in) &&
             (a_i == {1'b1, {(XLEN-1){1'b0}}}) && (b_i == '1);
    special_res = is_rem(op_in) ? '0 : a_i;
    if (is_dbz) special_res = is_rem(op_in) ? a_i : '1;
    accept = start_i & ~discard & (state_q == S_IDLE);
  end

`ifdef MULDIV_FAST_MUL_EN
  logic [AW-1:0] a_ext, b_ext, prod_fast;

  // Sign/zero-extend to 2*XLEN so the truncated product is exact for every multiply op.
  always_comb begin : fast_mul
    a_ext     = {{XLEN{sgn_a}}, a_i};
    b_ext     = {{XLEN{sgn_b}}, b_i};
    prod_fast = a_ext * b_ext;
    fast_hit  = !is_div(op_in);
    fast_res  = (op_in == OP_MUL) ? prod_fast[XLEN-1:0] : prod_fast[AW-1:XLEN];
  end
`else
  assign fast_hit = 1'b0;
  assign fast_res = '0;
`endif

  assign div_q = is_div(op_q);

  muldiv_step #(.XLEN(XLEN)) u_step (
    .div_op  (div_q),
    .acc     (acc_q),
    .opnd    (opnd_q),
    .acc_nxt (acc_step)
  );

  // Sign-correct the final step's magnitudes and pick the word the op asks for.
  always_comb begin : finish
    prod_s  = neg_q ? -acc_step : acc_step;
    quo_s   = neg_q ? -acc_step[XLEN-1:0] : acc_step[XLEN-1:0];
    rem_s   = neg_q ? -acc_step[AW-1:XLEN] : acc_step[AW-1:XLEN];
    fin_res = rem_s;
    case (op_q)
      OP_MUL:                       fin_res = prod_s[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fin_res = prod_s[AW-1:XLEN];
      OP_DIV, OP_DIVU:              fin_res = quo_s;
      default:                      fin_res = rem_s;
    endcase
  end

  always_comb begin : fsm_next
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    neg_d    = neg_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d   = op_in;
          neg_d  = neg_in;
          opnd_d = b_mag;
          acc_d  = {{XLEN{1'b0}}, a_mag};
          cnt_d  = '0;
          if (is_dbz || is_ovf) begin
            state_d  = S_FIN;
            done_d   = 1'b1;
            result_d = special_res;
          end else if (fast_hit) begin
            state_d  = S_FIN;
            done_d   = 1'b1;
            result_d = fast_res;
          end else begin
            state_d = S_CALC;
            busy_d  = 1'b1;
          end
        end
      end
      S_CALC: begin
        acc_d = acc_step;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d  = S_FIN;
          done_d   = 1'b1;
          result_d = fin_res;
        end else begin
          busy_d = 1'b1;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // A flush squashes whatever is in flight and leaves the last result visible.
    if (discard) begin
      state_d  = S_IDLE;
      busy_d   = 1'b0;
      done_d   = 1'b0;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk) begin : regs
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= OP_MUL;
      neg_q    <= 1'b0;
      opnd_q   <= '0;
      acc_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign result_o = result_q;
  assign stall_o  = start_i & ~discard & (state_q != S_FIN);

endmodule
